// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions for the decryption datapath.
//   - aes_byte_t / aes_col_t : 8-bit state byte and 32-bit state column
//   - AES_POLY              : low byte of the reduction polynomial x^8+x^4+x^3+x+1
//   - INV_C_*               : InvMixColumns matrix coefficients 0E/0B/0D/09
//   - xtime                 : multiply-by-x in GF(2^8)
//   - gf_mul_small          : multiply by a coefficient below 0x10 using only
//                             chained xtime and XOR
//   - imc_state_t           : control states of the column-serial engine
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_col_t;

  localparam aes_byte_t AES_POLY = 8'h1B;

  localparam aes_byte_t INV_C_E = 8'h0E;
  localparam aes_byte_t INV_C_B = 8'h0B;
  localparam aes_byte_t INV_C_D = 8'h0D;
  localparam aes_byte_t INV_C_9 = 8'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } imc_state_t;

  function automatic aes_byte_t xtime(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Coefficients are at most 0x0F, so x, 2x, 4x and 8x cover every term.
  function automatic aes_byte_t gf_mul_small(input aes_byte_t a, input aes_byte_t c);
    aes_byte_t x2;
    aes_byte_t x4;
    aes_byte_t x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? a  : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^
           (c[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// ---------------------------------------------------------------------------
// inv_mix_single_column
//   Purely combinational InvMixColumns for one 32-bit column.
//   Ports:
//     col_in  [31:0] : column a0..a3, a0 in the most significant byte
//     col_out [31:0] : column b0..b3, same byte order
// ---------------------------------------------------------------------------
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t b0, b1, b2, b3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  always_comb begin
    b0 = gf_mul_small(a0, INV_C_E) ^ gf_mul_small(a1, INV_C_B) ^
         gf_mul_small(a2, INV_C_D) ^ gf_mul_small(a3, INV_C_9);
    b1 = gf_mul_small(a0, INV_C_9) ^ gf_mul_small(a1, INV_C_E) ^
         gf_mul_small(a2, INV_C_B) ^ gf_mul_small(a3, INV_C_D);
    b2 = gf_mul_small(a0, INV_C_D) ^ gf_mul_small(a1, INV_C_9) ^
         gf_mul_small(a2, INV_C_E) ^ gf_mul_small(a3, INV_C_B);
    b3 = gf_mul_small(a0, INV_C_B) ^ gf_mul_small(a1, INV_C_D) ^
         gf_mul_small(a2, INV_C_9) ^ gf_mul_small(a3, INV_C_E);
  end

  assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_seq
//   Column-serial AES InvMixColumns with valid/ready on both sides.
//   COLS_PER_CYCLE columns (1, 2 or 4) are transformed per clock, so a block
//   takes N_ITER = 4/COLS_PER_CYCLE compute cycles.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     in_state [127:0], in_valid, in_ready    : input handshake
//     out_state[127:0], out_valid, out_ready  : output handshake
//   Byte k of a state is state[127-8k -: 8]; column c holds bytes 4c..4c+3.
// ---------------------------------------------------------------------------
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N_ITER = 4 / COLS_PER_CYCLE;
  localparam int SHIFT  = (COLS_PER_CYCLE == 4) ? 2 : (COLS_PER_CYCLE == 2) ? 1 : 0;
  localparam logic [1:0] LAST_CNT = 2'(N_ITER - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  imc_state_t   state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] src_q, src_d;
  logic [127:0] dst_q, dst_d;
  logic         out_valid_q, out_valid_d;

  // First column handled this cycle; the shift is col_cnt * COLS_PER_CYCLE.
  logic [1:0] col_base;
  assign col_base = col_cnt_q << SHIFT;

  logic [COLS_PER_CYCLE-1:0][31:0] col_src;
  logic [COLS_PER_CYCLE-1:0][31:0] col_res;

  // Pick the source columns for this iteration out of src_q.
  always_comb begin
    col_src = '0;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ((col_base + 2'(i)) == 2'(c)) begin
          col_src[i] = src_q[127-32*c -: 32];
        end
      end
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    inv_mix_single_column u_col (
      .col_in  (col_src[g]),
      .col_out (col_res[g])
    );
  end

  // In DONE the input side follows out_ready so a new block can enter in
  // the same cycle the finished one leaves.
  always_comb begin
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d     = in_state;
          col_cnt_d = 2'd0;
          state_d   = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          for (int c = 0; c < 4; c++) begin
            if ((col_base + 2'(i)) == 2'(c)) begin
              dst_d[127-32*c -: 32] = col_res[i];
            end
          end
        end
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            src_d     = in_state;
            col_cnt_d = 2'd0;
            state_d   = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      src_q       <= '0;
      dst_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_state = dst_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- AES InvMixColumns for the decryption datapath. It is the inverse of the encryption-side MixColumns stage and sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.
- Processes one 128-bit state per transaction using a column-serial iterative datapath.
- Valid/ready handshakes are used on both input and output.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- Derived constant N_ITER = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_state  input  128  state to transform.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept in_state this cycle.
- out_state  output  128  transformed state.
- out_valid  output  1  out_state is valid.
- out_ready  input  1  downstream accepts out_state.

Behaviour:
- Byte map:
  - byte k = state[127-8k -: 8], k = 0..15.
  - Column c = bytes 4c..4c+3; byte 4c+r is row r.
  - The same map is used on input and output.
- Per column (a0..a3), GF(2^8) arithmetic with polynomial 0x11B:
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - b2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - b3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
  - Products are built from chained xtime (x2, x4, x8) and XOR only; no LUT ROM.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch in_state into src_reg, col_cnt<=0, go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle transforms columns col_cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 from src_reg and writes them into the matching bytes of dst_reg.
  - col_cnt increments each cycle.
  - After the iteration where col_cnt==N_ITER-1, go to DONE.
- DONE:
  - out_valid=1; out_state = dst_reg, held stable until accepted.
  - in_ready = out_ready (combinational), so a new block can be accepted in the same cycle the result leaves.
  - out_ready & in_valid: latch the new in_state, go to CALC (back-to-back, no IDLE bubble).
  - out_ready & !in_valid: go to IDLE.
  - !out_ready: stay in DONE; dst_reg and out_state are unchanged and in_valid is ignored.
- Latency:
  - out_valid rises N_ITER rising edges after the accepting edge (4 for the default).
  - Throughput is one block per N_ITER+1 cycles under continuous handshakes.
- In CALC, input-side in_valid is ignored and no stall is possible, since the downstream is not yet involved.
- Reset (async assert, any state, including mid-CALC):
  - state=IDLE, col_cnt=0, src_reg=0, dst_reg=0.
  - out_valid=0, out_state=0, in_ready=1 while rst_n is high after release.
  - A partially computed block is discarded.
- col_cnt width is 2 bits. It wraps only by returning to 0 on a new acceptance and never indexes beyond N_ITER-1.
- No X propagation: out_state reflects dst_reg at all times and is 0 until the first completion.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY constant 8'h1B.
  - xtime function.
  - byte/column typedefs (8-bit byte, 32-bit column).
  - Inverse matrix coefficient constants 0E/0B/0D/09.
- One combinational sub-module inv_mix_single_column (32-bit in, 32-bit out), instantiated COLS_PER_CYCLE times.
- The FSM, counter and registers live in the top module.

Test Plan:
- Single block, COLS_PER_CYCLE=1:
  - Stimulus: in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_ready=1.
  - Response: out_valid rises 4 edges after acceptance, out_state=db135345_f20a225c_01010101_c6c6c6c6.
- Column vectors:
  - Stimulus: d5d5d7d6_4d7ebdf8_00000000_ffffffff.
  - Response: out_state=d4d4d4d5_2d26314c_00000000_ffffffff.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with a different state during the stall.
  - Response: out_state stays stable, in_ready=0, the second block is not accepted until out_ready=1; both results are correct and in order.
- Back-to-back:
  - Stimulus: in_valid and out_ready held at 1, three blocks streamed.
  - Response: a result every 5 cycles, the new block accepted in the same cycle as the previous result's handshake, no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (between edges) during the 2nd CALC cycle.
  - Response: out_valid=0 and out_state=0 immediately. After release, in_ready=1, and a fresh block produces the correct result.
- Parameter sweep:
  - Stimulus: COLS_PER_CYCLE=2 and 4 with the first test's vector.
  - Response: identical out_state, with latency 2 and 1 edges respectively.
